// File: rtl/mips_pkg.sv
// Shared definitions for the fetch/decode boundary: opcode constants,
// instruction field positions and the fetch state encoding.
package mips_pkg;

  localparam int INSTR_W    = 32;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic {
    REQ  = 1'b0,
    HOLD = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection: hold, sequential increment, or word-aligned branch target.
module pc_next_sel
  import mips_pkg::*;
#(
  parameter logic [31:0] PC_STEP = 32'd4
) (
  input  logic [INSTR_W-1:0] pc,
  input  logic               advance,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_target,
  output logic [31:0]        pc_next
);

  always_comb begin
    pc_next = pc;
    if (advance) begin
      // Targets are forced onto a word boundary; the low bits are dropped.
      if (redirect_valid) pc_next = {redirect_target[31:2], 2'b00};
      else                pc_next = pc + PC_STEP;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: requests the word at PC, latches it into the IR and
// offers it to decode; the PC advances or redirects only on the decode handshake.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target
);

  fetch_state_e       state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               req_q, req_d;
  logic               valid_q, valid_d;
  logic               fetch_done;
  logic               handshake;

  // The request flop stays low for the cycle after reset, so an ack arriving
  // then belongs to an abandoned request and is not accepted.
  assign fetch_done = (state_q == REQ) && req_q && imem_ack;
  assign handshake  = (state_q == HOLD) && valid_q && instr_ready;

  pc_next_sel #(
    .PC_STEP(32'(PC_STEP))
  ) u_pc_next_sel (
    .pc              (pc_q),
    .advance         (handshake),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .pc_next         (pc_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= REQ;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      req_q   <= req_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      REQ:     if (fetch_done) state_d = HOLD;
      HOLD:    if (handshake)  state_d = REQ;
      default: state_d = REQ;
    endcase
  end

  always_comb begin
    req_d   = (state_d == REQ);
    valid_d = (state_d == HOLD);
    ir_d    = ir_q;
    if (fetch_done) ir_d = imem_rdata;
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr_valid = valid_q;
  assign instr       = ir_q;
  assign opcode      = ir_q[OPCODE_MSB:OPCODE_LSB];
  assign pc_out      = pc_q;
  assign pc_plus4    = pc_q + 32'd4;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Producer side of the opcode interface that feeds the main control decoder.
- Holds the PC and fetches 32-bit instructions from instruction memory over a req/ack handshake.
- Latches each fetched word into an instruction register and presents it, with its 6-bit opcode, to the decode/control stage over a valid/ready handshake.
- Applies branch redirects returned by the execute stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, byte increment for sequential fetch.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- imem_req  out  1  instruction memory read request.
- imem_addr  out  32  read address; equals the PC; stable while imem_req=1.
- imem_ack  in  1  memory read complete; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  fetched instruction word.
- instr_valid  out  1  instr/opcode/pc_out hold a valid instruction.
- instr_ready  in  1  downstream accepts the instruction.
- instr  out  32  instruction register contents.
- opcode  out  6  instr[31:26], combinational from the IR.
- pc_out  out  32  PC of the presented instruction.
- pc_plus4  out  32  pc_out + 4, modulo 2^32.
- redirect_valid  in  1  take the branch target for the next fetch.
- redirect_target  in  32  branch target address.

Behaviour:
- Reset: clk and rst_n as above, reset synchronous and active-low. When rst_n=0 at a clk edge:
  - state=REQ, pc=RESET_PC, IR=0;
  - imem_req=0 and instr_valid=0 during the reset cycle;
  - opcode=0, pc_out=RESET_PC.
- State REQ:
  - imem_req=1, imem_addr=pc.
  - imem_ack=0: stay in REQ; address held.
  - imem_ack=1: IR<=imem_rdata, state<=HOLD.
- State HOLD:
  - imem_req=0, instr_valid=1. IR and pc_out stay stable until the handshake.
  - instr_ready=0: stay in HOLD.
  - instr_ready=1 (handshake): if redirect_valid=1, pc<={redirect_target[31:2],2'b00}; otherwise pc<=pc+PC_STEP. Then state<=REQ and instr_valid<=0.
- redirect_valid is sampled only on the handshake cycle and is ignored at all other times.
- Latency:
  - Zero-wait memory (ack in the first REQ cycle): instr_valid rises 1 cycle after imem_req rises.
  - Peak throughput is one instruction per 2 cycles.
  - Each extra wait cycle adds one cycle.
- Outputs are registered, except opcode and pc_plus4, which are combinational from IR and pc.
- Boundaries:
  - PC wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000; no flag raised.
  - Misaligned redirect: bits [1:0] are forced to 0.
  - imem_ack while state≠REQ: ignored; IR unchanged.
  - Reset during REQ: imem_req=0 in the reset cycle. The memory must not ack a request abandoned by reset; a stray ack in the reset cycle is ignored.
  - Reset during HOLD: the instruction is dropped, instr_valid=0, and refetch restarts from RESET_PC.
  - instr_ready with instr_valid=0: no effect.

Decomposition:
- Shared package mips_pkg:
  - opcode constants OP_RTYPE=6'h00, OP_BEQ=6'h04, OP_LW=6'h23, OP_SW=6'h2B;
  - INSTR_W=32, OPCODE_MSB=31, OPCODE_LSB=26;
  - the fetch state enum {REQ, HOLD}.
- One sub-module, pc_next_sel: combinational next-PC mux covering increment, redirect with alignment masking, and hold.

Test Plan:
- Zero-wait memory returns 32'h8C22_0004, ready held high. Required:
  - imem_addr sequence 0,4,8;
  - instr_valid 1 cycle after each req;
  - opcode=6'h23 for the first instruction.
- Memory acks after 3 wait cycles. Required:
  - imem_addr held at 0 for 4 cycles;
  - instr_valid=0 until the cycle after ack;
  - IR=ack data.
- Backpressure: instr_ready=0 for 5 cycles after instr_valid. Required:
  - instr and pc_out unchanged;
  - imem_req=0 throughout;
  - next imem_addr=4 only after ready.
- Redirect: handshake with redirect_valid=1, target=32'h0000_0043. Required:
  - next imem_addr=32'h0000_0040;
  - redirect_valid=1 on a non-handshake cycle is ignored and the next addr is pc+4.
- Wrap: RESET_PC=32'hFFFF_FFFC, one handshake. Required:
  - next imem_addr=32'h0000_0000;
  - pc_plus4 of the first instruction = 0.
- Reset: rst_n=0 for 1 cycle while in HOLD with pc=32'h10. Required:
  - instr_valid=0 and opcode=0;
  - the next imem_addr is RESET_PC.
